regs: RTL and testbench
=======================

// Module: regs
// PURPOSE
//  General-purpose register file for the core datapath: REGS_NUM words of BUS_WIDTH bits.
//  One write port and one read port, both addressed with full BUS_WIDTH addresses.
//  There is no write enable: the write port writes every clock edge.
//  Register 0 is hardwired to zero. Reads are registered and qualified by 'ready'.
// PARAMETERS
//  BUS_WIDTH  32  data width and address-port width, in bits
//  REGS_NUM   16  number of registers; valid addresses are 0..REGS_NUM-1
// PORTS
//  clk         in   1          single clock; all state updates on the rising edge
//  nreset      in   1          reset, asynchronous and active-high (asserted when 1)
//  addr_write  in   BUS_WIDTH  write address
//  data_write  in   BUS_WIDTH  write data
//  addr_read   in   BUS_WIDTH  read address
//  data_read   out  BUS_WIDTH  registered read data
//  ready       out  1          registered flag: data_read is valid for the captured address
// BEHAVIOUR
//  - Reset (nreset=1): takes effect immediately, without waiting for a clock edge.
//    All registers clear to 0, data_read=0 and ready=0; they stay so while nreset is held.
//  - Write: on each rising edge out of reset, reg[addr_write] <= data_write.
//    The write is ignored if addr_write==0 or addr_write>=REGS_NUM.
//    All BUS_WIDTH address bits are compared, so a high address never aliases to a low one.
//  - Read: data_read and ready are registered, with 1-cycle latency after addr_read is presented.
//    - If addr_read<REGS_NUM: data_read <= reg[addr_read] and ready <= 1.
//      Address 0 always returns 0.
//    - If addr_read>=REGS_NUM: data_read <= 0 and ready <= 0.
//  - Same-edge read/write to the same valid nonzero address: write-first.
//    data_read takes data_write (bypass), and the register also updates.
//  - Outputs change only on a clock edge or on reset. There is no combinational path from inputs to outputs.
//  - Reset asserted mid-operation: all state clears at once. The first edge after release performs a normal write and read.
//  - Width rule: register contents are stored and returned unmodified. No sign or zero extension is applied.
// STRUCTURE
//  - Shared package: ADDR_BITS = $clog2(REGS_NUM) constant, and a reg_word_t typedef of BUS_WIDTH bits.
//  - Single module. The storage array is an array of flops, not a RAM macro, so the asynchronous reset can clear it.
//  - Optional sub-module regs_bank holds storage plus write decode. The top level holds the read mux, bypass and output registers.
// TESTING
//  1. Pulse nreset=1 mid-clock -> data_read=0 and ready=0 immediately. After release, read addr 5 -> 0 with ready=1.
//  2. Write addr 1 = 2, then read addr 1 -> next edge data_read=2, ready=1.
//  3. Write addr 15 = 1, read addr 15 -> data_read=1. Read addr 16 -> data_read=0, ready=0.
//  4. Write addr 0 = 0xDEADBEEF, read addr 0 -> data_read=0, ready=1.
//  5. On the same edge write addr 3 = 0xA5A5A5A5 and read addr 3 -> data_read=0xA5A5A5A5 on that edge.
//  6. Write addr 0x10000001 = 7, read addr 1 -> reg 1 is unchanged (no aliasing).

Source files
------------

// File: rtl/regs_pkg.sv
// Shared constants and types for the datapath register file.
// The module parameters of regs and regs_bank default to these values.
package regs_pkg;

    localparam int unsigned BUS_WIDTH = 32;
    localparam int unsigned REGS_NUM  = 16;
    localparam int unsigned ADDR_BITS = $clog2(REGS_NUM);

    typedef logic [BUS_WIDTH-1:0] reg_word_t;

endpackage

// File: rtl/regs_bank.sv
// Register storage with write-address decode and a combinational read mux.
// Word 0 is never written, so it always holds the zero it was cleared to.
module regs_bank
    import regs_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = regs_pkg::BUS_WIDTH,
    parameter int unsigned REGS_NUM  = regs_pkg::REGS_NUM,
    parameter int unsigned IDX_BITS  = $clog2(REGS_NUM)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [BUS_WIDTH-1:0] addr_write,
    input  logic [BUS_WIDTH-1:0] data_write,
    input  logic [IDX_BITS-1:0]  rd_idx,
    output logic [BUS_WIDTH-1:0] rd_data
);

    logic [BUS_WIDTH-1:0] mem [REGS_NUM];
    logic                 wr_en;
    logic [IDX_BITS-1:0]  wr_idx;

    // Full-width compare so out-of-range addresses never alias into the array.
    always_comb begin
        wr_en  = (addr_write != '0) && (addr_write < BUS_WIDTH'(REGS_NUM));
        wr_idx = addr_write[IDX_BITS-1:0];
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            for (int unsigned i = 0; i < REGS_NUM; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= data_write;
        end
    end

    always_comb begin
        rd_data = mem[rd_idx];
    end

endmodule

// File: rtl/regs.sv
// General-purpose register file: one write port, one registered read port
// with write-first bypass and a ready flag for in-range read addresses.
module regs
    import regs_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = regs_pkg::BUS_WIDTH,
    parameter int unsigned REGS_NUM  = regs_pkg::REGS_NUM
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [BUS_WIDTH-1:0] addr_write,
    input  logic [BUS_WIDTH-1:0] data_write,
    input  logic [BUS_WIDTH-1:0] addr_read,
    output logic [BUS_WIDTH-1:0] data_read,
    output logic                 ready
);

    localparam int unsigned IDX_BITS = $clog2(REGS_NUM);

    logic [BUS_WIDTH-1:0] bank_rd_data;
    logic [BUS_WIDTH-1:0] rd_next;
    logic                 rd_valid;
    logic                 wr_valid;
    logic                 bypass;

    regs_bank #(
        .BUS_WIDTH (BUS_WIDTH),
        .REGS_NUM  (REGS_NUM),
        .IDX_BITS  (IDX_BITS)
    ) u_bank (
        .clk        (clk),
        .nreset     (nreset),
        .addr_write (addr_write),
        .data_write (data_write),
        .rd_idx     (addr_read[IDX_BITS-1:0]),
        .rd_data    (bank_rd_data)
    );

    // Bypass only for writes that actually land, so address 0 still reads 0.
    always_comb begin
        rd_valid = addr_read < BUS_WIDTH'(REGS_NUM);
        wr_valid = (addr_write != '0) && (addr_write < BUS_WIDTH'(REGS_NUM));
        bypass   = wr_valid && (addr_write == addr_read);
        rd_next  = '0;
        if (bypass) begin
            rd_next = data_write;
        end else if (rd_valid) begin
            rd_next = bank_rd_data;
        end
    end

    always_ff @(posedge clk or posedge nreset) begin
        if (nreset) begin
            data_read <= '0;
            ready     <= 1'b0;
        end else begin
            data_read <= rd_next;
            ready     <= rd_valid;
        end
    end

endmodule

// File: tb/tb_regs.sv
// Directed self-checking bench for the regs register file.
module tb_regs;
    import regs_pkg::*;

    logic      clk = 1'b0;
    logic      nreset;
    reg_word_t addr_write;
    reg_word_t data_write;
    reg_word_t addr_read;
    reg_word_t data_read;
    logic      ready;

    int checks   = 0;
    int failures = 0;

    regs #(
        .BUS_WIDTH (32),
        .REGS_NUM  (16)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .addr_write (addr_write),
        .data_write (data_write),
        .addr_read  (addr_read),
        .data_read  (data_read),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input reg_word_t obs_data, input logic obs_rdy,
                         input reg_word_t exp_data, input logic exp_rdy);
        checks++;
        assert (obs_data === exp_data && obs_rdy === exp_rdy)
        else begin
            failures++;
            $error("FAIL %s: observed data_read=%h ready=%b expected data_read=%h ready=%b",
                   tag, obs_data, obs_rdy, exp_data, exp_rdy);
        end
    endtask

    // Present inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input reg_word_t aw, input reg_word_t dw, input reg_word_t ar);
        @(negedge clk);
        addr_write = aw;
        data_write = dw;
        addr_read  = ar;
        @(posedge clk);
        #1;
    endtask

    initial begin
        nreset     = 1'b1;
        addr_write = '0;
        data_write = '0;
        addr_read  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", data_read, ready, 32'h0, 1'b0);

        @(negedge clk);
        nreset = 1'b0;
        step(32'd0, 32'd0, 32'd5);
        check("read5_after_reset", data_read, ready, 32'h0, 1'b1);

        step(32'd1, 32'd2, 32'd0);
        check("read0_during_write1", data_read, ready, 32'h0, 1'b1);
        step(32'd0, 32'd0, 32'd1);
        check("read1", data_read, ready, 32'd2, 1'b1);

        step(32'd15, 32'd1, 32'd0);
        step(32'd0, 32'd0, 32'd15);
        check("read15", data_read, ready, 32'd1, 1'b1);
        step(32'd0, 32'd0, 32'd16);
        check("read16_out_of_range", data_read, ready, 32'h0, 1'b0);
        step(32'd0, 32'd0, 32'hFFFF_FFFF);
        check("read_max_addr", data_read, ready, 32'h0, 1'b0);

        step(32'd0, 32'hDEAD_BEEF, 32'd0);
        check("write0_same_edge", data_read, ready, 32'h0, 1'b1);
        step(32'd0, 32'd0, 32'd0);
        check("read0_after_write0", data_read, ready, 32'h0, 1'b1);

        step(32'd3, 32'hA5A5_A5A5, 32'd3);
        check("bypass3", data_read, ready, 32'hA5A5_A5A5, 1'b1);
        step(32'd0, 32'd0, 32'd3);
        check("read3_stored", data_read, ready, 32'hA5A5_A5A5, 1'b1);

        step(32'h1000_0001, 32'd7, 32'd1);
        check("alias_same_edge", data_read, ready, 32'd2, 1'b1);
        step(32'd0, 32'd0, 32'd1);
        check("alias_read1", data_read, ready, 32'd2, 1'b1);

        step(32'd16, 32'h55, 32'd0);
        step(32'd0, 32'd0, 32'd0);
        check("write16_ignored", data_read, ready, 32'h0, 1'b1);

        step(32'd4, 32'hFFFF_FFFF, 32'd0);
        step(32'd0, 32'd0, 32'd4);
        check("full_width_word", data_read, ready, 32'hFFFF_FFFF, 1'b1);

        // Between edges the output must not follow a new read address.
        @(negedge clk);
        addr_read = 32'd1;
        #1;
        check("no_comb_path", data_read, ready, 32'hFFFF_FFFF, 1'b1);
        @(posedge clk);
        #1;
        check("read1_again", data_read, ready, 32'd2, 1'b1);

        step(32'd0, 32'd0, 32'd3);
        check("read3_before_reset", data_read, ready, 32'hA5A5_A5A5, 1'b1);
        #2;
        nreset = 1'b1;
        #1;
        check("async_reset_immediate", data_read, ready, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", data_read, ready, 32'h0, 1'b0);

        @(negedge clk);
        nreset     = 1'b0;
        addr_write = 32'd2;
        data_write = 32'h1234;
        addr_read  = 32'd2;
        @(posedge clk);
        #1;
        check("first_edge_after_release", data_read, ready, 32'h1234, 1'b1);
        step(32'd0, 32'd0, 32'd3);
        check("reg3_cleared", data_read, ready, 32'h0, 1'b1);
        step(32'd0, 32'd0, 32'd1);
        check("reg1_cleared", data_read, ready, 32'h0, 1'b1);
        step(32'd0, 32'd0, 32'd2);
        check("reg2_written", data_read, ready, 32'h1234, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
